// File: rtl/issue_scoreboard.sv
// issue_scoreboard: single-entry issue stage with a register scoreboard.
// Tracks pending register writes, stalls on RAW/WAW hazards and on a full
// in-flight budget, and allows a same-cycle writeback to release a hazard.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid / in_ready       decoded instruction handshake (in_ready is combinational)
//   in_raddr1/2, in_use_rs2   source operands
//   in_wen, in_waddr          destination write
//   out_valid / out_ready     issue register handshake
//   out_raddr1/2, out_waddr, out_wen   issue register fields
//   wb_valid, wb_addr         writeback completion
//   flush                     drop the issue register contents
//   busy, inflight            pending-write bits and their count
//   stall_cnt                 saturating stalled-cycle counter
//   wb_err                    sticky error: writeback to a non-busy register
module issue_scoreboard #(
   parameter int unsigned MAX_INFLIGHT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_raddr1,
   input  logic [3:0]  in_raddr2,
   input  logic        in_use_rs2,
   input  logic        in_wen,
   input  logic [3:0]  in_waddr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_raddr1,
   output logic [3:0]  out_raddr2,
   output logic [3:0]  out_waddr,
   output logic        out_wen,
   input  logic        wb_valid,
   input  logic [3:0]  wb_addr,
   input  logic        flush,
   output logic [15:0] busy,
   output logic [3:0]  inflight,
   output logic [15:0] stall_cnt,
   output logic        wb_err
);

   localparam int unsigned NREG = 16;
   localparam int unsigned CW   = 4;
   localparam int unsigned SW   = 16;

   logic            wb_live;
   logic [NREG-1:0] wb_vec;
   logic            wb_dec;
   logic            wb_bad;
   logic [NREG-1:0] eb;
   logic            wr_live;
   logic            full;
   logic            hazard;
   logic            accept;
   logic [NREG-1:0] set_vec;
   logic [NREG-1:0] drop_vec;
   logic [NREG-1:0] clr_vec;
   logic [NREG-1:0] busy_nxt;
   logic [CW-1:0]   dec_cnt;
   logic [CW-1:0]   inflight_nxt;
   logic            out_valid_nxt;

   // Hazard detection, handshake and scoreboard next-state
   always_comb begin
      wb_live  = wb_valid & (wb_addr != '0);
      wb_vec   = wb_live ? (NREG'(1) << wb_addr) : '0;
      wb_dec   = |(wb_vec & busy);
      wb_bad   = wb_live & ~busy[wb_addr];
      // same-cycle writeback bypass
      eb       = busy & ~wb_vec;
      wr_live  = in_wen & (in_waddr != '0);
      // budget frees up only if a real decrement happens this cycle
      full     = (inflight == CW'(MAX_INFLIGHT)) & ~wb_dec;
      hazard   = eb[in_raddr1]
               | (in_use_rs2 & eb[in_raddr2])
               | (wr_live & (eb[in_waddr] | full));
      in_ready = rst & ~hazard & ~flush & (~out_valid | out_ready);
      accept   = in_valid & in_ready;

      set_vec  = (accept & wr_live) ? (NREG'(1) << in_waddr) : '0;
      drop_vec = (flush & out_valid & out_wen & (out_waddr != '0))
                 ? (NREG'(1) << out_waddr) : '0;
      clr_vec  = (wb_vec | drop_vec) & busy;
      // a set on the same edge as a clear wins; counts cancel
      busy_nxt     = (busy & ~clr_vec) | set_vec;
      dec_cnt      = CW'($countones(clr_vec));
      inflight_nxt = inflight + CW'(|set_vec) - dec_cnt;

      out_valid_nxt = out_valid;
      if (flush)          out_valid_nxt = 1'b0;
      else if (accept)    out_valid_nxt = 1'b1;
      else if (out_ready) out_valid_nxt = 1'b0;
   end

   // Issue register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_raddr1 <= '0;
         out_raddr2 <= '0;
         out_waddr  <= '0;
         out_wen    <= 1'b0;
      end else begin
         out_valid <= out_valid_nxt;
         if (accept) begin
            out_raddr1 <= in_raddr1;
            out_raddr2 <= in_raddr2;
            out_waddr  <= in_waddr;
            out_wen    <= in_wen;
         end
      end
   end

   // Scoreboard state, error flag and stall counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= '0;
         inflight  <= '0;
         stall_cnt <= '0;
         wb_err    <= 1'b0;
      end else begin
         busy     <= busy_nxt;
         inflight <= inflight_nxt;
         if (wb_bad) wb_err <= 1'b1;
         if (in_valid && !in_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + SW'(1);
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed hazard scenarios with an
// expected-issue queue compared against the issue register every cycle.
module tb_issue_scoreboard;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_raddr1;
   logic [3:0]  in_raddr2;
   logic        in_use_rs2;
   logic        in_wen;
   logic [3:0]  in_waddr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_raddr1;
   logic [3:0]  out_raddr2;
   logic [3:0]  out_waddr;
   logic        out_wen;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic        flush;
   logic [15:0] busy;
   logic [3:0]  inflight;
   logic [15:0] stall_cnt;
   logic        wb_err;

   typedef struct packed {
      logic [3:0] r1;
      logic [3:0] r2;
      logic [3:0] wa;
      logic       we;
   } iss_t;

   iss_t q[$];
   iss_t e;
   logic mv;
   int   sc;
   int   n_checks;
   int   n_errors;

   issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_raddr1  (in_raddr1),
      .in_raddr2  (in_raddr2),
      .in_use_rs2 (in_use_rs2),
      .in_wen     (in_wen),
      .in_waddr   (in_waddr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_raddr1 (out_raddr1),
      .out_raddr2 (out_raddr2),
      .out_waddr  (out_waddr),
      .out_wen    (out_wen),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .flush      (flush),
      .busy       (busy),
      .inflight   (inflight),
      .stall_cnt  (stall_cnt),
      .wb_err     (wb_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle, entered and left at a falling edge. Checks the handshake,
   // issue register and stall counter against the model, then updates it.
   task automatic cyc(input int iv, input int r1, input int r2, input int u2,
                      input int we, input int wa, input int ordy,
                      input int wbv, input int wba, input int fl, input int exp_rdy);
      in_valid   = 1'(iv);
      in_raddr1  = 4'(r1);
      in_raddr2  = 4'(r2);
      in_use_rs2 = 1'(u2);
      in_wen     = 1'(we);
      in_waddr   = 4'(wa);
      out_ready  = 1'(ordy);
      wb_valid   = 1'(wbv);
      wb_addr    = 4'(wba);
      flush      = 1'(fl);
      #1;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("stall_cnt", 32'(stall_cnt), 32'(sc));
      if (mv) begin
         if (q.size() == 0) begin
            check("queue_nonempty", 32'(q.size()), 32'(1));
         end else begin
            check("out_fields", 32'({out_raddr1, out_raddr2, out_waddr, out_wen}), 32'(q[0]));
         end
      end
      if (mv && (ordy != 0 || fl != 0) && q.size() > 0) void'(q.pop_front());
      if (fl != 0)                   mv = 1'b0;
      else if (iv != 0 && exp_rdy != 0) mv = 1'b1;
      else if (ordy != 0)            mv = 1'b0;
      if (iv != 0 && exp_rdy != 0 && fl == 0) begin
         e.r1 = 4'(r1);
         e.r2 = 4'(r2);
         e.wa = 4'(wa);
         e.we = 1'(we);
         q.push_back(e);
      end
      if (iv != 0 && exp_rdy == 0 && sc != 32'hFFFF) sc++;
      @(negedge clk);
   endtask

   task automatic idle(input int ordy, input int wbv, input int wba, input int fl);
      cyc(0, 0, 0, 0, 0, 0, ordy, wbv, wba, fl, int'(fl == 0 && (!mv || ordy != 0)));
   endtask

   task automatic chk_sb(input string tag, input int exp_busy, input int exp_inf);
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      check({tag, "_inflight"}, 32'(inflight), 32'(exp_inf));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      mv = 1'b0;
      sc = 0;
      rst = 1'b0;
      in_valid = 1'b0; in_raddr1 = '0; in_raddr2 = '0; in_use_rs2 = 1'b0;
      in_wen = 1'b0; in_waddr = '0; out_ready = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
      in_valid = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      chk_sb("rst", 0, 0);
      check("rst_wb_err", 32'(wb_err), 32'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // RAW hazard on r3, released by same-cycle writeback
      cyc(1, 0, 0, 0, 1, 3, 1, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cyc(1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      chk_sb("raw", 16'h0008, 1);
      cyc(1, 3, 0, 0, 0, 0, 1, 1, 3, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("raw_done", 0, 0);

      // In-flight budget: r1..r4 fill it, r5 waits for writeback of r2
      for (int k = 1; k <= 4; k++) cyc(1, 0, 0, 0, 1, k, 1, 0, 0, 0, 1);
      chk_sb("full", 16'h001E, 4);
      cyc(1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 5, 1, 1, 2, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("full_swap", 16'h003A, 4);
      idle(1, 1, 1, 0);
      idle(1, 1, 3, 0);
      idle(1, 1, 4, 0);
      idle(1, 1, 5, 0);
      chk_sb("full_clean", 0, 0);

      // Same-edge set and clear of r5: set wins
      cyc(1, 0, 0, 0, 1, 5, 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 1, 5, 1, 1, 5, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("setclr", 16'h0020, 1);
      idle(1, 1, 5, 0);
      chk_sb("setclr_clean", 0, 0);

      // r0 is never busy
      for (int k = 0; k < 4; k++) cyc(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("r0", 0, 0);

      // Flush drops a held write to r9; flush with empty register only blocks
      cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1);
      chk_sb("flush_pre", 16'h0200, 1);
      idle(0, 0, 0, 1);
      check("flush_out_valid", 32'(out_valid), 32'(0));
      chk_sb("flush_post", 0, 0);
      cyc(1, 0, 0, 0, 1, 9, 1, 0, 0, 1, 0);
      chk_sb("flush_empty", 0, 0);

      // Backpressure for 3 cycles, then one instruction per cycle
      cyc(1, 1, 2, 1, 1, 6, 0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) cyc(1, 1, 2, 1, 1, 7, 0, 0, 0, 0, 0);
      cyc(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 1);
      cyc(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 1);
      cyc(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("bp", 16'h01C0, 3);
      idle(1, 1, 6, 0);
      idle(1, 1, 7, 0);
      idle(1, 1, 8, 0);
      chk_sb("bp_clean", 0, 0);

      // Writeback errors: r0 ignored, non-busy r7 flagged and sticky
      idle(1, 1, 0, 0);
      check("wb_err_r0", 32'(wb_err), 32'(0));
      idle(1, 1, 7, 0);
      check("wb_err_r7", 32'(wb_err), 32'(1));
      chk_sb("wb_err", 0, 0);
      idle(1, 0, 0, 0);
      idle(1, 0, 0, 0);
      check("wb_err_sticky", 32'(wb_err), 32'(1));

      // Reset mid-operation, then accept on the first edge after release
      cyc(1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 1);
      chk_sb("pre_rst", 16'h0400, 1);
      in_valid = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'(0));
      check("mid_rst_out_valid", 32'(out_valid), 32'(0));
      check("mid_rst_fields", 32'({out_raddr1, out_raddr2, out_waddr, out_wen}), 32'(0));
      chk_sb("mid_rst", 0, 0);
      check("mid_rst_stall", 32'(stall_cnt), 32'(0));
      check("mid_rst_wb_err", 32'(wb_err), 32'(0));
      q.delete();
      mv = 1'b0;
      sc = 0;
      @(negedge clk);
      rst = 1'b1;
      cyc(1, 10, 0, 0, 1, 10, 1, 0, 0, 0, 1);
      idle(1, 0, 0, 0);
      chk_sb("post_rst", 16'h0400, 1);
      idle(1, 1, 10, 0);
      chk_sb("post_rst_clean", 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001: Parameter MAX_INFLIGHT, default 4, range 1-15: maximum outstanding register writes.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, asynchronous and active-low.
REQ-004: in_valid  input  1  decoded instruction present.
REQ-005: in_ready  output  1  instruction accepted when in_valid & in_ready.
REQ-006: in_raddr1, in_raddr2  input  4 each  source register addresses.
REQ-007: in_use_rs2  input  1  raddr2 is a real operand.
REQ-008: in_wen, in_waddr  input  1, 4  destination write enable and address.
REQ-009: out_valid  output  1  issue register holds an instruction.
REQ-010: out_ready  input  1  downstream accepts the issue register.
REQ-011: out_raddr1, out_raddr2, out_waddr, out_wen  output  4, 4, 4, 1  registered copies of accepted fields.
REQ-012: wb_valid, wb_addr  input  1, 4  writeback completion for wb_addr.
REQ-013: flush  input  1  discard the issue register contents.
REQ-014: busy  output  16  per-register pending-write bits.
REQ-015: inflight  output  4  count of set busy bits.
REQ-016: stall_cnt  output  16  saturating count of stalled cycles.
REQ-017: wb_err  output  1  sticky: writeback to a non-busy register.

Function
REQ-018: Register 0 shall never be busy; any write or writeback to address 0 is ignored for busy, inflight and wb_err.
REQ-019: Effective busy eb = busy with bit wb_addr cleared when wb_valid (same-cycle writeback bypass).
REQ-020: hazard = eb[raddr1] | (in_use_rs2 & eb[raddr2]) | (in_wen & waddr!=0 & eb[waddr]) | (in_wen & waddr!=0 & inflight==MAX_INFLIGHT & no wb decrement this cycle).
REQ-021: in_ready = ~hazard & ~flush & (~out_valid | out_ready); combinational, no dependence on in_valid.
REQ-022: On accept, fields load into the issue register next edge and out_valid=1 (latency 1 cycle).
REQ-023: Accept with in_wen & waddr!=0 sets busy[waddr] at the same edge the issue register loads.
REQ-024: out_valid clears on out_ready with no new accept; back-to-back accept with out_ready sustains 1 instruction/cycle.
REQ-025: wb_valid to a busy register clears its bit next edge; wb_valid to a non-busy nonzero register sets wb_err and changes nothing else.
REQ-026: Same-edge set and clear of the same address: set wins, bit stays 1, inflight unchanged.
REQ-027: inflight tracks popcount(busy) incrementally: +1 set, -1 clear, net 0 when both; never exceeds MAX_INFLIGHT.
REQ-028: flush: out_valid clears next edge; if dropped instruction had out_wen & waddr!=0, its busy bit clears and inflight decrements; no accept that cycle.
REQ-029: flush with out_valid=0 shall have no effect besides blocking accept.
REQ-030: stall_cnt increments each cycle in_valid & ~in_ready, saturates at 0xFFFF.
REQ-031: out_* fields hold their value while out_valid & ~out_ready.

Reset
REQ-032: rst low asynchronously forces out_valid=0, busy=0, inflight=0, stall_cnt=0, wb_err=0, out_* fields=0.
REQ-033: Reset mid-operation discards all pending state; first accept allowed on the first edge after release.
REQ-034: During reset in_ready=0.

Verification
REQ-035: Issue wen waddr=3, then next instr raddr1=3 with no wb -> in_ready=0, stall_cnt counts; wb_valid addr=3 -> accept that same cycle.
REQ-036: MAX_INFLIGHT=4, issue writes to r1..r4, then write to r5 -> stalled; wb r2 same cycle -> r5 accepted, inflight stays 4.
REQ-037: wb_addr=7 with busy[7]=0 -> wb_err=1 sticky until reset; busy unchanged.
REQ-038: Issue write r9, out_ready=0, assert flush -> out_valid=0, busy[9]=0, inflight decremented.
REQ-039: out_ready held 0 for 3 cycles with in_valid=1 -> out_* stable, stall_cnt +3; release -> 1 instr/cycle throughput.
REQ-040: Write to r0 and read r0 repeatedly -> never stalls, busy[0]=0, inflight=0.
